dma_ahb_arbiter: RTL and testbench
==================================

# dma_ahb_arbiter

Shares the MAC's single AHB master port between the receive DMA engine and the transmit DMA engine. Each engine drives its own AHB master signals and a bus-request line. The arbiter grants one engine at a time, muxes the address phase from the granted engine, and tracks data-phase ownership separately so that HWDATA, HREADY and error status reach the correct engine across a handover. It sits between the two DMA engines and the top-level AHB master pins.

## Interface
- RR_EN, default 1: 1 = round-robin between RX and TX; 0 = fixed priority, RX wins.
- HCLK  in  1  system clock; all logic on rising edge.
- HRESETN  in  1  reset, synchronous, active-low.
- rx_req  in  1  RX engine bus request; held high for the whole burst sequence.
- rx_htrans  in  2  RX engine HTRANS.
- rx_haddr  in  30  RX engine HADDR[31:2].
- rx_hwrite  in  1  RX engine HWRITE.
- rx_hwdata  in  32  RX engine HWDATA.
- rx_gnt  out  1  RX owns the address phase.
- rx_hready  out  1  HREADY as seen by the RX engine.
- rx_err  out  1  one-cycle pulse: an RX data phase ended with ERROR.
- tx_req, tx_htrans, tx_haddr, tx_hwrite, tx_hwdata, tx_gnt, tx_hready, tx_err: same as the RX set, for the TX engine.
- HTRANS  out  2  shared bus HTRANS.
- HADDR  out  30  shared HADDR[31:2].
- HWRITE  out  1  shared HWRITE.
- HWDATA  out  32  shared HWDATA.
- HREADY  in  1  slave ready.
- HRESP  in  2  slave response; 00 OKAY, 01 ERROR.
- HRDATA is broadcast to both engines at the top level and is not routed through this block.

## Operation
- Registered address owner `aown` takes one of {NONE, RX, TX}. Registered data owner `down` takes the same set. Registered `last` is {RX, TX}.
- Arbitration point: any cycle with HREADY=1 and either aown=NONE or the current owner's req=0.
  - At an arbitration point, aown_next is chosen from the active requests.
  - RR_EN=1, both requesting: grant the engine that is not `last`.
  - RR_EN=0, both requesting: grant RX.
  - One requester: grant it.
  - No requester: NONE.
  - On every grant to RX or TX, `last` is updated to that engine.
- An owner that keeps its req high is never preempted, including while the other engine requests.
- Address-phase mux (combinational from aown):
  - HTRANS, HADDR and HWRITE come from the owner's inputs.
  - aown=NONE drives HTRANS=00, HADDR=0, HWRITE=0.
- Data-phase tracking, on HREADY=1:
  - down <= aown when HTRANS[1]=1 (NONSEQ or SEQ).
  - Otherwise down <= NONE.
  - When HREADY=0, down holds.
- HWDATA is muxed from down; down=NONE drives 0.
- Per-engine ready:
  - x_hready = HREADY when aown==x or down==x; otherwise 0.
  - A non-granted engine therefore stalls with its address held.
- Error: x_err = (down==x) & HREADY & (HRESP==01). It is combinational, one cycle per errored transfer, and causes no ownership change.
- x_gnt = (aown==x).

## Timing
- Reset (HRESETN=0 at a rising edge):
  - aown=NONE, down=NONE, last=TX, so RX wins the first tie.
  - Outputs: HTRANS=00, HADDR=0, HWRITE=0, HWDATA=0, both gnt=0, both err=0, both hready=0.
- Reset applied mid-burst forces the same state on the next edge. Any in-flight data phase is abandoned.
- Grant latency: a request seen at an arbitration point in cycle N gives gnt=1 and the engine's HTRANS on the bus in cycle N+1.
- Handover: the old owner drops req in cycle N with HREADY=1, so the new owner drives the address in N+1. The old owner's final data phase completes in N+1 under `down`, with HWDATA taken from the old owner.
- Wait states: with HREADY=0, aown, down and last all hold. A req drop during the wait is acted on at the first HREADY=1 cycle.
- Both engines raising req in the same cycle from idle is resolved by the tie rule. The loser sees hready=0 until it is granted.
- Back-to-back alternation under constant requests: each engine gets one burst sequence per turn, with no idle cycle inserted between owners.

## Test plan
- Reset, then rx_req=1 in cycle 3 → rx_gnt=1 in cycle 4; HTRANS=rx_htrans=10 and HADDR=rx_haddr in cycle 4; tx_hready=0 throughout.
- RX owns the bus doing a write with rx_hwdata=0xA5A5A5A5. RX drops req and TX requests in the same cycle with HREADY=1 → in the next cycle HADDR=tx_haddr and HWDATA=0xA5A5A5A5.
- Both engines request constantly with RR_EN=1, and each drops req after 4 beats → grants go RX, TX, RX, TX. With RR_EN=0 and the same stimulus, grants go RX every time while rx_req is high.
- Hold HREADY=0 for 3 cycles during a handover → HADDR, gnt and HWDATA are unchanged across the stall; the handover happens on the first HREADY=1 cycle.
- TX data phase gets HRESP=01 over two cycles (HREADY 0 then 1) → tx_err=1 for exactly one cycle and rx_err=0.
- Assert HRESETN=0 mid TX burst → next cycle HTRANS=00, tx_gnt=0, HWDATA=0; a pending rx_req is granted one cycle after reset is released.

Source files
------------

// File: rtl/dma_ahb_arbiter.sv
// Shares one AHB master port between the RX and TX DMA engines. The address phase follows
// the address owner; HWDATA, ready and error follow the registered data-phase owner.
module dma_ahb_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        HCLK,
    input  logic        HRESETN,

    input  logic        rx_req,
    input  logic [1:0]  rx_htrans,
    input  logic [29:0] rx_haddr,
    input  logic        rx_hwrite,
    input  logic [31:0] rx_hwdata,
    output logic        rx_gnt,
    output logic        rx_hready,
    output logic        rx_err,

    input  logic        tx_req,
    input  logic [1:0]  tx_htrans,
    input  logic [29:0] tx_haddr,
    input  logic        tx_hwrite,
    input  logic [31:0] tx_hwdata,
    output logic        tx_gnt,
    output logic        tx_hready,
    output logic        tx_err,

    output logic [1:0]  HTRANS,
    output logic [29:0] HADDR,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [1:0]  HRESP
);

    typedef enum logic [1:0] {
        OwnNone = 2'd0,
        OwnRx   = 2'd1,
        OwnTx   = 2'd2
    } own_e;

    own_e aown_q, aown_d;
    own_e down_q;
    logic last_tx_q;
    logic arb_point;
    logic resp_err;

    // The current owner is only released once it drops req and the bus is ready.
    always_comb begin
        arb_point = HREADY && ((aown_q == OwnNone) ||
                               ((aown_q == OwnRx) && !rx_req) ||
                               ((aown_q == OwnTx) && !tx_req));
        aown_d = aown_q;
        if (arb_point) begin
            if (rx_req && tx_req) begin
                aown_d = (RR_EN && !last_tx_q) ? OwnTx : OwnRx;
            end else if (rx_req) begin
                aown_d = OwnRx;
            end else if (tx_req) begin
                aown_d = OwnTx;
            end else begin
                aown_d = OwnNone;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETN) begin
            aown_q    <= OwnNone;
            down_q    <= OwnNone;
            last_tx_q <= 1'b1;
        end else begin
            aown_q <= aown_d;
            if (HREADY) begin
                down_q <= HTRANS[1] ? aown_q : OwnNone;
            end
            if (arb_point && (aown_d != OwnNone)) begin
                last_tx_q <= (aown_d == OwnTx);
            end
        end
    end

    always_comb begin
        HTRANS = 2'b00;
        HADDR  = '0;
        HWRITE = 1'b0;
        unique case (aown_q)
            OwnRx: begin
                HTRANS = rx_htrans;
                HADDR  = rx_haddr;
                HWRITE = rx_hwrite;
            end
            OwnTx: begin
                HTRANS = tx_htrans;
                HADDR  = tx_haddr;
                HWRITE = tx_hwrite;
            end
            default: begin
                HTRANS = 2'b00;
                HADDR  = '0;
                HWRITE = 1'b0;
            end
        endcase
    end

    always_comb begin
        HWDATA = '0;
        unique case (down_q)
            OwnRx:   HWDATA = rx_hwdata;
            OwnTx:   HWDATA = tx_hwdata;
            default: HWDATA = '0;
        endcase
    end

    assign resp_err  = HREADY && (HRESP == 2'b01);

    assign rx_gnt    = (aown_q == OwnRx);
    assign tx_gnt    = (aown_q == OwnTx);
    assign rx_hready = ((aown_q == OwnRx) || (down_q == OwnRx)) ? HREADY : 1'b0;
    assign tx_hready = ((aown_q == OwnTx) || (down_q == OwnTx)) ? HREADY : 1'b0;
    assign rx_err    = (down_q == OwnRx) && resp_err;
    assign tx_err    = (down_q == OwnTx) && resp_err;

endmodule

// File: tb/tb_dma_ahb_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with the same stimulus and compares
// both against an ownership model kept in the bench.
module tb_dma_ahb_arbiter;

    logic        HCLK = 1'b0;
    logic        HRESETN;
    logic        rx_req, tx_req;
    logic [1:0]  rx_htrans, tx_htrans;
    logic [29:0] rx_haddr, tx_haddr;
    logic        rx_hwrite, tx_hwrite;
    logic [31:0] rx_hwdata, tx_hwdata;
    logic        HREADY;
    logic [1:0]  HRESP;

    logic [1:0]  o_rx_gnt, o_rx_hready, o_rx_err, o_tx_gnt, o_tx_hready, o_tx_err, o_hwrite;
    logic [1:0]  o_htrans [2];
    logic [29:0] o_haddr  [2];
    logic [31:0] o_hwdata [2];

    always #5 HCLK = ~HCLK;

    dma_ahb_arbiter #(.RR_EN(1'b1)) u_rr (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .rx_req(rx_req), .rx_htrans(rx_htrans), .rx_haddr(rx_haddr), .rx_hwrite(rx_hwrite),
        .rx_hwdata(rx_hwdata), .rx_gnt(o_rx_gnt[0]), .rx_hready(o_rx_hready[0]),
        .rx_err(o_rx_err[0]),
        .tx_req(tx_req), .tx_htrans(tx_htrans), .tx_haddr(tx_haddr), .tx_hwrite(tx_hwrite),
        .tx_hwdata(tx_hwdata), .tx_gnt(o_tx_gnt[0]), .tx_hready(o_tx_hready[0]),
        .tx_err(o_tx_err[0]),
        .HTRANS(o_htrans[0]), .HADDR(o_haddr[0]), .HWRITE(o_hwrite[0]), .HWDATA(o_hwdata[0]),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    dma_ahb_arbiter #(.RR_EN(1'b0)) u_fp (
        .HCLK(HCLK), .HRESETN(HRESETN),
        .rx_req(rx_req), .rx_htrans(rx_htrans), .rx_haddr(rx_haddr), .rx_hwrite(rx_hwrite),
        .rx_hwdata(rx_hwdata), .rx_gnt(o_rx_gnt[1]), .rx_hready(o_rx_hready[1]),
        .rx_err(o_rx_err[1]),
        .tx_req(tx_req), .tx_htrans(tx_htrans), .tx_haddr(tx_haddr), .tx_hwrite(tx_hwrite),
        .tx_hwdata(tx_hwdata), .tx_gnt(o_tx_gnt[1]), .tx_hready(o_tx_hready[1]),
        .tx_err(o_tx_err[1]),
        .HTRANS(o_htrans[1]), .HADDR(o_haddr[1]), .HWRITE(o_hwrite[1]), .HWDATA(o_hwdata[1]),
        .HREADY(HREADY), .HRESP(HRESP)
    );

    // Model: 0 = nobody, 1 = RX, 2 = TX; index 0 is round-robin, 1 is fixed priority.
    int m_aown [2] = '{0, 0};
    int m_down [2] = '{0, 0};
    int m_last [2] = '{2, 2};
    int checks = 0;
    int passed = 0;
    int fails  = 0;
    string phase = "reset";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s/%s: got %0h expected %0h", phase, tag, obs, exp);
        end
    endtask

    function automatic int winner(input int inst);
        if (rx_req && tx_req) begin
            if (inst == 1) return 1;
            return (m_last[inst] == 1) ? 2 : 1;
        end
        if (rx_req) return 1;
        if (tx_req) return 2;
        return 0;
    endfunction

    function automatic logic [1:0] bus_htrans(input int owner);
        if (owner == 1) return rx_htrans;
        if (owner == 2) return tx_htrans;
        return 2'b00;
    endfunction

    task automatic check_all();
        int a, d;
        logic [29:0] e_addr;
        logic [31:0] e_wd;
        logic e_wr;
        for (int i = 0; i < 2; i++) begin
            a = m_aown[i];
            d = m_down[i];
            e_addr = (a == 1) ? rx_haddr : (a == 2) ? tx_haddr : 30'd0;
            e_wr   = (a == 1) ? rx_hwrite : (a == 2) ? tx_hwrite : 1'b0;
            e_wd   = (d == 1) ? rx_hwdata : (d == 2) ? tx_hwdata : 32'd0;
            chk($sformatf("u%0d HTRANS", i), 32'(o_htrans[i]), 32'(bus_htrans(a)));
            chk($sformatf("u%0d HADDR", i), 32'(o_haddr[i]), 32'(e_addr));
            chk($sformatf("u%0d HWRITE", i), 32'(o_hwrite[i]), 32'(e_wr));
            chk($sformatf("u%0d HWDATA", i), o_hwdata[i], e_wd);
            chk($sformatf("u%0d rx_gnt", i), 32'(o_rx_gnt[i]), 32'(a == 1));
            chk($sformatf("u%0d tx_gnt", i), 32'(o_tx_gnt[i]), 32'(a == 2));
            chk($sformatf("u%0d rx_hready", i), 32'(o_rx_hready[i]),
                32'(HREADY && (a == 1 || d == 1)));
            chk($sformatf("u%0d tx_hready", i), 32'(o_tx_hready[i]),
                32'(HREADY && (a == 2 || d == 2)));
            chk($sformatf("u%0d rx_err", i), 32'(o_rx_err[i]),
                32'(d == 1 && HREADY && HRESP == 2'b01));
            chk($sformatf("u%0d tx_err", i), 32'(o_tx_err[i]),
                32'(d == 2 && HREADY && HRESP == 2'b01));
        end
    endtask

    task automatic update_model();
        int a, w;
        bit holds;
        for (int i = 0; i < 2; i++) begin
            a = m_aown[i];
            if (!HRESETN) begin
                m_aown[i] = 0;
                m_down[i] = 0;
                m_last[i] = 2;
            end else if (HREADY) begin
                m_down[i] = bus_htrans(a)[1] ? a : 0;
                holds = (a == 1 && rx_req) || (a == 2 && tx_req);
                if (!holds) begin
                    w = winner(i);
                    m_aown[i] = w;
                    if (w != 0) m_last[i] = w;
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        check_all();
        @(posedge HCLK);
        update_model();
        @(negedge HCLK);
    endtask

    initial begin
        int seq [$];
        int prev, own, obs_own, beats_rx, beats_tx;

        HRESETN = 1'b0; HREADY = 1'b1; HRESP = 2'b00;
        rx_req = 1'b0; rx_htrans = 2'b00; rx_haddr = '0; rx_hwrite = 1'b0; rx_hwdata = '0;
        tx_req = 1'b0; tx_htrans = 2'b00; tx_haddr = '0; tx_hwrite = 1'b0; tx_hwdata = '0;
        @(negedge HCLK);
        tick();
        #1;
        chk("rst HTRANS", 32'(o_htrans[0]), 0);
        chk("rst rx_gnt", 32'(o_rx_gnt[0]), 0);
        chk("rst tx_hready", 32'(o_tx_hready[0]), 0);
        tick();

        // First grant, then handover from an RX write to TX.
        phase = "grant";
        HRESETN = 1'b1;
        rx_req = 1'b1; rx_htrans = 2'b10; rx_haddr = 30'h400; rx_hwrite = 1'b1;
        rx_hwdata = 32'hA5A5A5A5;
        tx_htrans = 2'b10; tx_haddr = 30'h800; tx_hwdata = 32'h5A5A0001;
        #1 chk("c3 tx_hready", 32'(o_tx_hready[0]), 0);
        tick();
        #1;
        chk("c4 rx_gnt", 32'(o_rx_gnt[0]), 1);
        chk("c4 HTRANS", 32'(o_htrans[0]), 2);
        chk("c4 HADDR", 32'(o_haddr[0]), 32'h400);
        chk("c4 tx_hready", 32'(o_tx_hready[0]), 0);
        rx_htrans = 2'b11;
        tick();
        phase = "handover";
        rx_req = 1'b0; tx_req = 1'b1;
        tick();
        #1;
        chk("ho HADDR", 32'(o_haddr[0]), 32'h800);
        chk("ho HWDATA", o_hwdata[0], 32'hA5A5A5A5);
        chk("ho tx_gnt", 32'(o_tx_gnt[1]), 1);
        rx_htrans = 2'b00;
        tick();

        // TX error over a wait state.
        phase = "error";
        tx_htrans = 2'b11; HREADY = 1'b0; HRESP = 2'b01;
        #1 chk("err wait tx_err", 32'(o_tx_err[0]), 0);
        tick();
        HREADY = 1'b1;
        #1;
        chk("err tx_err", 32'(o_tx_err[0]), 1);
        chk("err rx_err", 32'(o_rx_err[0]), 0);
        tick();
        HRESP = 2'b00;
        #1 chk("err done tx_err", 32'(o_tx_err[0]), 0);

        // Handover stalled by three wait states.
        phase = "stall";
        tx_req = 1'b0; rx_req = 1'b1; rx_htrans = 2'b10; rx_haddr = 30'h123; HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall tx_gnt", 32'(o_tx_gnt[0]), 1);
            chk("stall HADDR", 32'(o_haddr[0]), 32'h800);
            chk("stall HWDATA", o_hwdata[0], 32'h5A5A0001);
            tick();
        end
        HREADY = 1'b1;
        #1 chk("stall release tx_gnt", 32'(o_tx_gnt[0]), 1);
        tick();
        #1;
        chk("stall new rx_gnt", 32'(o_rx_gnt[0]), 1);
        chk("stall new HADDR", 32'(o_haddr[0]), 32'h123);

        // Reset in the middle of a TX burst with RX pending.
        phase = "midreset";
        rx_req = 1'b0; tx_req = 1'b1; tx_htrans = 2'b10; tx_hwrite = 1'b1;
        tick();
        tx_htrans = 2'b11; rx_req = 1'b1;
        tick();
        #1 chk("no preempt rx_gnt", 32'(o_rx_gnt[0]), 0);
        HRESETN = 1'b0;
        tick();
        HRESETN = 1'b1;
        #1;
        chk("mr HTRANS", 32'(o_htrans[0]), 0);
        chk("mr tx_gnt", 32'(o_tx_gnt[0]), 0);
        chk("mr HWDATA", o_hwdata[0], 0);
        tick();
        #1;
        chk("mr rx_gnt rr", 32'(o_rx_gnt[0]), 1);
        chk("mr rx_gnt fp", 32'(o_rx_gnt[1]), 1);

        // Ties from idle: RX first, then round-robin alternates while fixed stays on RX.
        phase = "tie";
        HRESETN = 1'b0;
        tick();
        HRESETN = 1'b1;
        tick();
        #1 chk("tie1 rx_gnt rr", 32'(o_rx_gnt[0]), 1);
        rx_req = 1'b0; tx_req = 1'b0;
        tick();
        rx_req = 1'b1; tx_req = 1'b1;
        tick();
        #1;
        chk("tie2 tx_gnt rr", 32'(o_tx_gnt[0]), 1);
        chk("tie2 rx_gnt fp", 32'(o_rx_gnt[1]), 1);

        // Constant requests, each engine releases after four beats.
        phase = "rr";
        HRESETN = 1'b0;
        tick();
        HRESETN = 1'b1;
        beats_rx = 0; beats_tx = 0; prev = 0;
        for (int k = 0; k < 30; k++) begin
            own = m_aown[0];
            rx_req = !(own == 1 && beats_rx == 3);
            tx_req = !(own == 2 && beats_tx == 3);
            rx_htrans = (own == 1 && beats_rx != 0) ? 2'b11 : 2'b10;
            tx_htrans = (own == 2 && beats_tx != 0) ? 2'b11 : 2'b10;
            #1;
            obs_own = o_rx_gnt[0] ? 1 : (o_tx_gnt[0] ? 2 : 0);
            if (obs_own != prev && obs_own != 0) seq.push_back(obs_own);
            prev = obs_own;
            tick();
            if (own == 1) beats_rx = (beats_rx == 3) ? 0 : beats_rx + 1;
            if (own == 2) beats_tx = (beats_tx == 3) ? 0 : beats_tx + 1;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr grant %0d", k), (seq.size() > k) ? seq[k] : 0, (k % 2) + 1);
        end

        // Random traffic against the model.
        phase = "random";
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(7) == 0) rx_req = ~rx_req;
            if ($urandom_range(7) == 0) tx_req = ~tx_req;
            rx_htrans = 2'($urandom); tx_htrans = 2'($urandom);
            rx_haddr = 30'($urandom); tx_haddr = 30'($urandom);
            rx_hwrite = 1'($urandom); tx_hwrite = 1'($urandom);
            rx_hwdata = $urandom; tx_hwdata = $urandom;
            HREADY = ($urandom_range(3) != 0);
            HRESP = ($urandom_range(4) == 0) ? 2'b01 : 2'b00;
            HRESETN = ($urandom_range(99) != 0);
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
